// File: rtl/iter_divider.sv
// Radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu in EXE.
// Holds the pipeline via div_stall and presents q/r until EXE acks.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_x,
    input  logic [WIDTH-1:0] div_y,
    input  logic             div_cancel,
    input  logic             div_ack,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_r
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] ya_q, ya_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             yz_q, yz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [WIDTH:0]   shift, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] xa, ya;

    assign xa = (div_signed & div_x[WIDTH-1]) ? -div_x : div_x;
    assign ya = (div_signed & div_y[WIDTH-1]) ? -div_y : div_y;

    // One restoring step on the full WIDTH+1-bit partial remainder
    assign shift  = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = shift - {1'b0, ya_q};
    assign ge     = shift >= {1'b0, ya_q};
    assign rem_nx = ge ? diff[WIDTH-1:0] : shift[WIDTH-1:0];
    assign quo_nx = {dvd_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        ya_d    = ya_q;
        x_d     = x_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        yz_d    = yz_q;
        q_d     = q_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (div_en) begin
                    dvd_d   = xa;
                    ya_d    = ya;
                    x_d     = div_x;
                    qneg_d  = div_signed & (div_x[WIDTH-1] ^ div_y[WIDTH-1]);
                    rneg_d  = div_signed & div_x[WIDTH-1];
                    yz_d    = (div_y == '0);
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (yz_q) begin
                        q_d = '1;
                        r_d = x_q;
                    end else begin
                        q_d = qneg_q ? -quo_nx : quo_nx;
                        r_d = rneg_q ? -rem_nx : rem_nx;
                    end
                end
            end
            DONE: begin
                if (div_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (div_cancel) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            ya_q    <= '0;
            x_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            yz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            ya_q    <= ya_d;
            x_q     <= x_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            yz_q    <= yz_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign div_stall = div_en & (state_q != DONE) & ~div_cancel & resetn;
    assign div_done  = (state_q == DONE);
    assign div_q     = q_q;
    assign div_r     = r_q;
endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver queues expected q/r,
// monitor pops and compares on each rising div_done.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_en = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] div_x = '0;
    logic [31:0] div_y = '0;
    logic        div_cancel = 1'b0;
    logic        div_ack = 1'b0;
    logic        div_stall, div_done;
    logic [31:0] div_q, div_r;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [31:0] last_q, last_r;
    logic        seen = 1'b0;

    iter_divider #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .div_en(div_en),
        .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_cancel(div_cancel), .div_ack(div_ack),
        .div_stall(div_stall), .div_done(div_done),
        .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on each rising edge of div_done
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && div_done && !seen) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk("q", div_q, e[63:32]);
                    chk("r", div_r, e[31:0]);
                end
            end
            seen = resetn & div_done;
        end
    end

    always @(negedge clk) begin
        if (resetn)
            assert (!(dut.state_q == 2'd1 && !div_en && !div_cancel))
            else $error("div_en dropped while busy");
    end

    task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                            input logic s, input logic [31:0] eq,
                            input logic [31:0] er);
        div_x = x;
        div_y = y;
        div_signed = s;
        div_en = 1'b1;
        last_q = eq;
        last_r = er;
        sb.push_back({eq, er});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        int b = 0;
        do begin
            @(negedge clk);
            if (div_stall) n++;
            b++;
        end while (!div_done && b < 100);
        chk({name, "_stall_cycles"}, n, 33);
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", {31'd0, div_done}, 32'd1);
            chk("hold_stall", {31'd0, div_stall}, 32'd0);
            chk("hold_q", div_q, last_q);
            chk("hold_r", div_r, last_r);
        end
    endtask

    task automatic do_ack(input bit keep);
        div_ack = 1'b1;
        @(posedge clk);
        #1;
        div_ack = 1'b0;
        if (!keep) div_en = 1'b0;
        chk("ack_done_drop", {31'd0, div_done}, 32'd0);
    endtask

    task automatic full_op(input string name, input logic [31:0] x,
                           input logic [31:0] y, input logic s,
                           input logic [31:0] eq, input logic [31:0] er);
        start_op(x, y, s, eq, er);
        wait_done(name);
        do_ack(1'b0);
    endtask

    initial begin
        #1 #20;
        chk("rst_stall", {31'd0, div_stall}, 32'd0);
        chk("rst_done", {31'd0, div_done}, 32'd0);
        chk("rst_q", div_q, 32'd0);
        chk("rst_r", div_r, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        full_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        full_op("sm100_7", 32'hFFFFFF9C, 32'd7, 1'b1,
                32'hFFFFFFF2, 32'hFFFFFFFE);
        full_op("s100_m7", 32'd100, 32'hFFFFFFF9, 1'b1,
                32'hFFFFFFF2, 32'd2);
        full_op("sm7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1,
                32'd3, 32'hFFFFFFFF);
        full_op("s_div0", 32'h12345678, 32'd0, 1'b1,
                32'hFFFFFFFF, 32'h12345678);
        full_op("u_div0", 32'h12345678, 32'd0, 1'b0,
                32'hFFFFFFFF, 32'h12345678);
        full_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
                32'h80000000, 32'd0);
        full_op("u_big", 32'h80000000, 32'hFFFFFFFF, 1'b0,
                32'd0, 32'h80000000);

        // Cancel at cycle 10 of an op; no result may appear
        div_x = 32'd1000;
        div_y = 32'd3;
        div_signed = 1'b0;
        div_en = 1'b1;
        repeat (10) @(posedge clk);
        #1 div_cancel = 1'b1;
        @(negedge clk);
        chk("cancel_stall", {31'd0, div_stall}, 32'd0);
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        div_en = 1'b0;
        chk("cancel_done", {31'd0, div_done}, 32'd0);
        @(posedge clk);
        #1;
        full_op("after_cancel", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

        // Held in DONE with div_en high, then back-to-back op
        start_op(32'd77, 32'd10, 1'b0, 32'd7, 32'd7);
        wait_done("held");
        hold(5);
        start_op(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF);
        do_ack(1'b1);
        chk("b2b_stall", {31'd0, div_stall}, 32'd1);
        last_q = 32'h0FFFFFFF;
        begin
            int n = 1;
            int b = 0;
            do begin
                @(negedge clk);
                b++;
                if (div_stall && b > 1) n++;
            end while (!div_done && b < 100);
            chk("b2b_stall_cycles", n, 33);
        end
        do_ack(1'b0);

        // Async reset between edges mid-BUSY
        div_x = 32'd500;
        div_y = 32'd9;
        div_en = 1'b1;
        repeat (6) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("arst_stall", {31'd0, div_stall}, 32'd0);
        chk("arst_done", {31'd0, div_done}, 32'd0);
        chk("arst_q", div_q, 32'd0);
        chk("arst_r", div_r, 32'd0);
        div_en = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        full_op("after_rst", 32'd500, 32'd9, 1'b0, 32'd55, 32'd5);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
